// File: rtl/hazard_ctrl_pkg.sv
// rv32i_types: shared FSM state type and NOP encoding for the hazard controller.
package rv32i_types;
    typedef enum logic {RUN, REDIRECT_WAIT} hazard_state_t;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline hazard status in, stage enables/flushes/redirect/counters out.
interface hazard_ctrl_if #(parameter int XLEN = 32, parameter int CNT_W = 32);
    logic imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
    logic stall_ex_mem, stall_mem_wb;
    logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
    logic if_id_uses_rs1, if_id_uses_rs2, id_ex_mem_read;
    logic ex_br_taken;
    logic [XLEN-1:0] ex_br_target;
    logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic flush_if_id, flush_id_ex, pc_redirect, redirect_pending;
    logic [XLEN-1:0] redirect_pc;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    modport master (
        output imem_read, imem_resp, dmem_read, dmem_write, dmem_resp, stall_ex_mem, stall_mem_wb,
               if_id_rs1, if_id_rs2, id_ex_rd, if_id_uses_rs1, if_id_uses_rs2, id_ex_mem_read,
               ex_br_taken, ex_br_target,
        input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex,
               pc_redirect, redirect_pending, redirect_pc, stall_cnt, flush_cnt
    );
    modport slave (
        input  imem_read, imem_resp, dmem_read, dmem_write, dmem_resp, stall_ex_mem, stall_mem_wb,
               if_id_rs1, if_id_rs2, id_ex_rd, if_id_uses_rs1, if_id_uses_rs2, id_ex_mem_read,
               ex_br_taken, ex_br_target,
        output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex,
               pc_redirect, redirect_pending, redirect_pc, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: synchronous-reset up counter that sticks at all-ones.
module sat_counter #(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (inc && cnt_q != '1) ? cnt_q + WIDTH'(1) : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/redirect control with a pending-redirect FSM and perf counters.
module hazard_ctrl
    import rv32i_types::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave hif
);
    hazard_state_t   state_q, state_d;
    logic [XLEN-1:0] target_q, target_d, rpc;
    logic [4:0]      ld;
    logic            flush_if, flush_id, redir, stall_inc, flush_inc;
    logic            dmem_wait, imem_wait, back_freeze, load_use;

    assign dmem_wait   = (hif.dmem_read | hif.dmem_write) & ~hif.dmem_resp;
    assign imem_wait   = hif.imem_read & ~hif.imem_resp;
    assign back_freeze = dmem_wait | ~hif.stall_ex_mem | ~hif.stall_mem_wb;
    assign load_use    = hif.id_ex_mem_read && hif.id_ex_rd != 5'd0 &&
                         ((hif.if_id_uses_rs1 && hif.if_id_rs1 == hif.id_ex_rd) ||
                          (hif.if_id_uses_rs2 && hif.if_id_rs2 == hif.id_ex_rd));

    // ld bit order: pc, if_id, id_ex, ex_mem, mem_wb
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        ld        = '0;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        redir     = 1'b0;
        rpc       = '0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (!rst) begin
            if (state_q == RUN) begin
                if (back_freeze) begin
                    stall_inc = 1'b1;
                end else if (hif.ex_br_taken) begin
                    ld        = imem_wait ? 5'b01111 : 5'b11111;
                    flush_if  = 1'b1;
                    flush_id  = 1'b1;
                    flush_inc = 1'b1;
                    redir     = ~imem_wait;
                    rpc       = imem_wait ? '0 : hif.ex_br_target;
                    target_d  = imem_wait ? hif.ex_br_target : target_q;
                    state_d   = imem_wait ? REDIRECT_WAIT : RUN;
                end else if (load_use) begin
                    ld        = 5'b00111;
                    flush_id  = 1'b1;
                    stall_inc = 1'b1;
                end else if (imem_wait) begin
                    ld        = 5'b01111;
                    flush_if  = 1'b1;
                    stall_inc = 1'b1;
                end else begin
                    ld = 5'b11111;
                end
            end else begin
                // only bubbles sit in ID here, so the front end ignores the back-end freeze
                ld        = {~imem_wait, 1'b1, {3{~back_freeze}}};
                flush_if  = 1'b1;
                redir     = ~imem_wait;
                rpc       = imem_wait ? '0 : target_q;
                stall_inc = imem_wait | back_freeze;
                state_d   = imem_wait ? REDIRECT_WAIT : RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    assign {hif.load_pc, hif.load_if_id, hif.load_id_ex, hif.load_ex_mem, hif.load_mem_wb} = ld;
    assign hif.flush_if_id      = flush_if;
    assign hif.flush_id_ex      = flush_id;
    assign hif.pc_redirect      = redir;
    assign hif.redirect_pc      = rpc;
    assign hif.redirect_pending = ~rst & (state_q == REDIRECT_WAIT);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(stall_inc), .cnt(hif.stall_cnt));
    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(flush_inc), .cnt(hif.flush_cnt));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven single-cycle vectors plus hand sequences for stalls, redirects and saturation.
module tb_hazard_ctrl;
    localparam int XLEN  = 32;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) hif ();
    hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .hif(hif));

    // ctl bits: imem_read imem_resp dmem_read dmem_write dmem_resp stall_ex_mem stall_mem_wb uses_rs1 uses_rs2 mem_read br
    typedef struct {
        string       name;
        logic [10:0] ctl;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] tgt;
        logic [4:0]  e_ld;
        logic [1:0]  e_fl;
        logic        e_rd;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(string n, logic [10:0] c, logic [4:0] r1, logic [4:0] r2, logic [4:0] d,
                                logic [31:0] t, logic [4:0] l, logic [1:0] f, logic r, logic [31:0] p);
        vec_t v;
        v.name = n; v.ctl = c; v.rs1 = r1; v.rs2 = r2; v.rd = d; v.tgt = t;
        v.e_ld = l; v.e_fl = f; v.e_rd = r; v.e_pc = p;
        return v;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(logic [10:0] c, logic [4:0] r1, logic [4:0] r2, logic [4:0] d, logic [31:0] t);
        {hif.imem_read, hif.imem_resp, hif.dmem_read, hif.dmem_write, hif.dmem_resp, hif.stall_ex_mem,
         hif.stall_mem_wb, hif.if_id_uses_rs1, hif.if_id_uses_rs2, hif.id_ex_mem_read, hif.ex_br_taken} = c;
        hif.if_id_rs1 = r1; hif.if_id_rs2 = r2; hif.id_ex_rd = d; hif.ex_br_target = t;
    endtask

    function automatic logic [4:0] loads();
        return {hif.load_pc, hif.load_if_id, hif.load_id_ex, hif.load_ex_mem, hif.load_mem_wb};
    endfunction

    function automatic logic [1:0] flushes();
        return {hif.flush_if_id, hif.flush_id_ex};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(11'b00000_11_0000, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [10:0] QUIET = 11'b00000_11_0000;
    vec_t vecs[15];

    initial begin
        vecs[0]  = mk("quiet",      QUIET,            0, 0, 0, 0,     5'b11111, 2'b00, 0, 0);
        vecs[1]  = mk("lu_rs2",     11'b00000_11_0110, 0, 5, 5, 0,     5'b00111, 2'b01, 0, 0);
        vecs[2]  = mk("lu_rs1",     11'b00000_11_1010, 7, 0, 7, 0,     5'b00111, 2'b01, 0, 0);
        vecs[3]  = mk("lu_rd0",     11'b00000_11_1010, 0, 0, 0, 0,     5'b11111, 2'b00, 0, 0);
        vecs[4]  = mk("lu_nouse",   11'b00000_11_0010, 5, 5, 5, 0,     5'b11111, 2'b00, 0, 0);
        vecs[5]  = mk("lu_noload",  11'b00000_11_1100, 5, 5, 5, 0,     5'b11111, 2'b00, 0, 0);
        vecs[6]  = mk("dmem_wait",  11'b00100_11_0000, 0, 0, 0, 0,     5'b00000, 2'b00, 0, 0);
        vecs[7]  = mk("dmem_wr_ok", 11'b00011_11_0000, 0, 0, 0, 0,     5'b11111, 2'b00, 0, 0);
        vecs[8]  = mk("mem_wb_hold",11'b00000_10_0000, 0, 0, 0, 0,     5'b00000, 2'b00, 0, 0);
        vecs[9]  = mk("imem_wait",  11'b10000_11_0000, 0, 0, 0, 0,     5'b01111, 2'b10, 0, 0);
        vecs[10] = mk("imem_ok",    11'b11000_11_0000, 0, 0, 0, 0,     5'b11111, 2'b00, 0, 0);
        vecs[11] = mk("br",         11'b00000_11_0001, 0, 0, 0, 32'h60, 5'b11111, 2'b11, 1, 32'h60);
        vecs[12] = mk("br_frozen",  11'b00000_01_0001, 0, 0, 0, 32'h70, 5'b00000, 2'b00, 0, 0);
        vecs[13] = mk("br_over_lu", 11'b00000_11_1011, 3, 0, 3, 32'h44, 5'b11111, 2'b11, 1, 32'h44);
        vecs[14] = mk("lu_over_iw", 11'b10000_11_1010, 9, 0, 9, 0,     5'b00111, 2'b01, 0, 0);

        // reset held with busy inputs
        drive(11'b10101_00_1111, 1, 1, 1, 32'h123);
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_loads", 32'(loads()), 0);
            chk("rst_flush", 32'(flushes()), 0);
            chk("rst_redir", 32'(hif.pc_redirect), 0);
            chk("rst_pending", 32'(hif.redirect_pending), 0);
        end
        do_reset();
        #1;
        chk("post_rst_loads", 32'(loads()), 32'h1f);
        chk("post_rst_stall_cnt", 32'(hif.stall_cnt), 0);
        chk("post_rst_flush_cnt", 32'(hif.flush_cnt), 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].ctl, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].tgt);
            #1;
            chk({vecs[i].name, "_loads"}, 32'(loads()), 32'(vecs[i].e_ld));
            chk({vecs[i].name, "_flush"}, 32'(flushes()), 32'(vecs[i].e_fl));
            chk({vecs[i].name, "_redir"}, 32'(hif.pc_redirect), 32'(vecs[i].e_rd));
            if (vecs[i].e_rd) chk({vecs[i].name, "_rpc"}, hif.redirect_pc, vecs[i].e_pc);
        end
        @(negedge clk);
        drive(11'b00100_11_0000, 0, 0, 0, 0);
        #1;
        chk("table_stall_cnt", 32'(hif.stall_cnt), 7);
        chk("table_flush_cnt", 32'(hif.flush_cnt), 2);
        @(negedge clk); #1;
        chk("stall_cnt_saturate", 32'(hif.stall_cnt), 7);

        // three-cycle data-memory wait
        do_reset();
        drive(11'b00100_11_0000, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1 chk("dwait_loads", 32'(loads()), 0);
            @(negedge clk);
        end
        drive(11'b00101_11_0000, 0, 0, 0, 0);
        #1 chk("dwait_resp_loads", 32'(loads()), 32'h1f);
        @(negedge clk); #1;
        chk("dwait_stall_cnt", 32'(hif.stall_cnt), 3);

        // branch during an outstanding fetch
        do_reset();
        drive(11'b10000_11_0001, 0, 0, 0, 32'h80);
        #1;
        chk("rw_enter_loads", 32'(loads()), 32'h0f);
        chk("rw_enter_flush", 32'(flushes()), 3);
        chk("rw_enter_redir", 32'(hif.pc_redirect), 0);
        @(negedge clk);
        drive(11'b10100_11_0001, 0, 0, 0, 32'h99);
        #1;
        chk("rw_wait_pending", 32'(hif.redirect_pending), 1);
        chk("rw_wait_loads", 32'(loads()), 32'h08);
        chk("rw_wait_flush", 32'(flushes()), 2);
        chk("rw_wait_redir", 32'(hif.pc_redirect), 0);
        @(negedge clk);
        drive(11'b11000_11_0000, 0, 0, 0, 0);
        #1;
        chk("rw_resp_pending", 32'(hif.redirect_pending), 1);
        chk("rw_resp_redir", 32'(hif.pc_redirect), 1);
        chk("rw_resp_rpc", hif.redirect_pc, 32'h80);
        chk("rw_resp_loads", 32'(loads()), 32'h1f);
        chk("rw_resp_flush", 32'(flushes()), 2);
        @(negedge clk);
        drive(QUIET, 0, 0, 0, 0);
        #1;
        chk("rw_exit_pending", 32'(hif.redirect_pending), 0);
        chk("rw_exit_loads", 32'(loads()), 32'h1f);
        chk("rw_flush_cnt", 32'(hif.flush_cnt), 1);

        // branch held by a freeze, taken on the first unfrozen cycle
        do_reset();
        drive(11'b00000_01_0001, 0, 0, 0, 32'h60);
        #1;
        chk("frz_br_loads", 32'(loads()), 0);
        chk("frz_br_redir", 32'(hif.pc_redirect), 0);
        @(negedge clk);
        drive(11'b00000_11_0001, 0, 0, 0, 32'h60);
        #1;
        chk("unfrz_br_redir", 32'(hif.pc_redirect), 1);
        chk("unfrz_br_rpc", hif.redirect_pc, 32'h60);
        @(negedge clk);
        drive(QUIET, 0, 0, 0, 0);
        #1;
        chk("frz_br_flush_cnt", 32'(hif.flush_cnt), 1);
        chk("frz_br_stall_cnt", 32'(hif.stall_cnt), 1);

        // reset while a redirect is pending drops it
        do_reset();
        drive(11'b10000_11_0001, 0, 0, 0, 32'hA0);
        @(negedge clk);
        drive(11'b10000_11_0000, 0, 0, 0, 0);
        #1 chk("pre_rst_pending", 32'(hif.redirect_pending), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(11'b11000_11_0000, 0, 0, 0, 0);
        #1;
        chk("rst_drop_pending", 32'(hif.redirect_pending), 0);
        chk("rst_drop_redir", 32'(hif.pc_redirect), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
